issue_ctrl: RTL
===============

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: dec_valid  input  1  decode stage holds a valid instruction.
REQ-004 SHALL have port: dec_cond  input  4  condition field, instruction[31:28].
REQ-005 SHALL have port: dec_src_mask  input  16  one-hot-per-register mask of registers read.
REQ-006 SHALL have ports: dec_dst_en  input  1, dec_dst  input  4  destination register write request and index.
REQ-007 SHALL have ports: dec_set_flags  input  1  S bit; dec_use_flags  input  1  dec_cond is not AL.
REQ-008 SHALL have ports: ex_flags_we  input  1, ex_flags  input  4  NZCV update from ALU, {N,Z,C,V}.
REQ-009 SHALL have ports: wb_en  input  1, wb_addr  input  4  register writeback retire.
REQ-010 SHALL have port: flush  input  1  kill the instruction in decode (taken branch).
REQ-011 SHALL have ports: stall_if  output  1  combinational freeze for fetch/decode; issue_valid  output  1; issue_nop  output  1; issue_dst  output  4; stall_cnt  output  8.

Function
REQ-012 SHALL keep a 16-bit pending scoreboard and a flags_busy bit.
REQ-013 SHALL keep a 4-bit flag register, loaded from ex_flags when ex_flags_we=1.
REQ-014 SHALL compute hazard = dec_valid & ~flush & ((dec_src_mask & pending_eff) != 0 | (dec_use_flags & flags_busy_eff)).
REQ-015 SHALL drive stall_if = hazard, combinationally in the same cycle.
REQ-016 SHALL run a two-state FSM: RUN (no hazard last cycle) and HOLD (stalling); RUN->HOLD on hazard, HOLD->RUN when hazard clears or on flush.
REQ-017 SHALL, when dec_valid & ~hazard & ~flush, register issue_valid=1 next cycle (1-cycle latency), issue_dst=dec_dst.
REQ-018 SHALL evaluate conditions: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 always fails.
REQ-019 SHALL register issue_nop=1 with issue_valid=1 when the condition fails; a NOP SHALL NOT set pending or flags_busy.
REQ-020 SHALL, on non-NOP issue, set pending[dec_dst] if dec_dst_en and set flags_busy if dec_set_flags.
REQ-021 SHALL clear pending[wb_addr] on wb_en and clear flags_busy on ex_flags_we; a same-cycle set of the same bit wins over its clear.
REQ-022 SHALL, on flush, register issue_valid=0 and leave the scoreboard and flags unchanged (in-flight writes still retire).
REQ-023 SHALL increment stall_cnt each cycle stall_if=1, saturating at 255.
REQ-024 SHALL ignore wb_en for register 15 in the scoreboard (PC never pending).

Reset
REQ-025 SHALL, on rst_n=0, immediately clear pending=0, flags_busy=0, flags=0, FSM=RUN, issue_valid=0, issue_nop=0, issue_dst=0, stall_cnt=0.
REQ-026 SHALL, on reset asserted mid-stall, drop stall_if to 0 in the same cycle because pending and flags_busy clear.

Configuration
REQ-027 SHALL support macro ISSUE_CTRL_BYPASS_EN.
REQ-028 With ISSUE_CTRL_BYPASS_EN defined: pending_eff = pending & ~onehot(wb_addr) when wb_en; flags_busy_eff = flags_busy & ~ex_flags_we; condition evaluation uses ex_flags when ex_flags_we=1.
REQ-029 Without ISSUE_CTRL_BYPASS_EN: pending_eff = pending, flags_busy_eff = flags_busy, condition evaluation uses the flag register only (same-cycle retire still stalls one cycle).

Verification
REQ-030 SHALL cover: issue dst=R3, next instruction src_mask=0x0008, wb of R3 three cycles later -> stall_if=1 until the retire (with bypass) or one cycle after it (without bypass); stall_cnt counts the stall cycles.
REQ-031 SHALL cover: flags=0100 (Z=1), dec_cond=0001 (NE) -> issue_valid=1, issue_nop=1, and pending stays unchanged despite dec_dst_en=1.
REQ-032 SHALL cover: flags_busy=1, dec_cond=0000 (EQ), ex_flags_we=1 with ex_flags=0100 -> with bypass, issue same cycle, issue_nop=0.
REQ-033 SHALL cover: issue dst=R5 coinciding with wb_addr=5, wb_en=1 -> pending[5]=1 afterwards.
REQ-034 SHALL cover: flush during HOLD -> stall_if=0, next issue_valid=0, FSM=RUN, pending unchanged.
REQ-035 SHALL cover: 300 consecutive stall cycles -> stall_cnt=255; then rst_n=0 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order issue control: register/flag scoreboard, condition check, stall FSM
// Optional same-cycle retire bypass is enabled with `define ISSUE_CTRL_BYPASS_EN.
module issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    input  logic [3:0]  dec_cond,
    input  logic [15:0] dec_src_mask,
    input  logic        dec_dst_en,
    input  logic [3:0]  dec_dst,
    input  logic        dec_set_flags,
    input  logic        dec_use_flags,
    input  logic        ex_flags_we,
    input  logic [3:0]  ex_flags,
    input  logic        wb_en,
    input  logic [3:0]  wb_addr,
    input  logic        flush,
    output logic        stall_if,
    output logic        issue_valid,
    output logic        issue_nop,
    output logic [3:0]  issue_dst,
    output logic [7:0]  stall_cnt
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] pending;
    logic [15:0] pending_eff;
    logic [15:0] pending_next;
    logic [15:0] wb_mask;
    logic [15:0] set_mask;
    logic        flags_busy;
    logic        flags_busy_eff;
    logic        flags_busy_next;
    logic [3:0]  flags;
    logic [3:0]  cond_flags;
    logic        cond_pass;
    logic        hazard;
    logic        do_issue;
    logic        real_issue;

    // Condition codes over {N,Z,C,V}; 4'b1111 is treated as never-execute.
    function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic pass;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'b0000: pass = z;
            4'b0001: pass = ~z;
            4'b0010: pass = c;
            4'b0011: pass = ~c;
            4'b0100: pass = n;
            4'b0101: pass = ~n;
            4'b0110: pass = v;
            4'b0111: pass = ~v;
            4'b1000: pass = c & ~z;
            4'b1001: pass = ~c | z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = ~z & (n == v);
            4'b1101: pass = z | (n != v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    // R15 is the PC: it never becomes pending, so its writeback is ignored too.
    always_comb begin
        wb_mask = 16'h0000;
        if (wb_en && (wb_addr != 4'd15)) begin
            wb_mask = 16'h0001 << wb_addr;
        end
    end

`ifdef ISSUE_CTRL_BYPASS_EN
    assign pending_eff    = pending & ~wb_mask;
    assign flags_busy_eff = flags_busy & ~ex_flags_we;
    assign cond_flags     = ex_flags_we ? ex_flags : flags;
`else
    assign pending_eff    = pending;
    assign flags_busy_eff = flags_busy;
    assign cond_flags     = flags;
`endif

    assign cond_pass  = eval_cond(dec_cond, cond_flags);
    assign hazard     = dec_valid & ~flush &
                        ((|(dec_src_mask & pending_eff)) | (dec_use_flags & flags_busy_eff));
    assign stall_if   = hazard;
    assign do_issue   = dec_valid & ~hazard & ~flush;
    assign real_issue = do_issue & cond_pass;

    // The set is applied after the clear so a same-cycle reissue keeps the bit.
    always_comb begin
        set_mask = 16'h0000;
        if (real_issue && dec_dst_en && (dec_dst != 4'd15)) begin
            set_mask = 16'h0001 << dec_dst;
        end
        pending_next    = (pending & ~wb_mask) | set_mask;
        flags_busy_next = (flags_busy & ~ex_flags_we) | (real_issue & dec_set_flags);
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (hazard) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!hazard || flush) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            pending    <= 16'h0000;
            flags_busy <= 1'b0;
            flags      <= 4'h0;
        end else begin
            state      <= state_next;
            pending    <= pending_next;
            flags_busy <= flags_busy_next;
            if (ex_flags_we) begin
                flags <= ex_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid <= 1'b0;
            issue_nop   <= 1'b0;
            issue_dst   <= 4'h0;
        end else if (do_issue) begin
            issue_valid <= 1'b1;
            issue_nop   <= ~cond_pass;
            issue_dst   <= dec_dst;
        end else begin
            issue_valid <= 1'b0;
            issue_nop   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 8'h00;
        end else if (hazard && (stall_cnt != 8'hFF)) begin
            stall_cnt <= stall_cnt + 8'h01;
        end
    end

endmodule
